b16_uart_port: RTL and testbench

Memory-mapped I/O port between the b16 CPU bus and the `uart` transmitter/receiver. It decodes the top I/O window 0xFFFC–0xFFFF, which the top level selects with `sel[2]`. It buffers received bytes in an RX FIFO and outgoing bytes in a TX FIFO, and drives the uart's one-byte strobe handshake. Its output feeds the `4'b1100` read case of the top-level data mux.

---
 rtl/b16_uart_port.sv | 156 +++++++++++++++
 tb/tb_b16_uart_port.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/b16_uart_port.sv
// b16 memory-mapped UART port: RX/TX byte FIFOs, status/data registers and the uart strobe handshake.
// Optional internal loopback is built only when B16_UART_LOOPBACK_EN is defined.
module b16_uart_port #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic        en,
    input  logic        addr1,
    input  logic        r,
    input  logic [1:0]  w,
    input  logic [15:0] dwrite,
    output logic [15:0] rdata,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_strobe,
    input  logic        tx_busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {IDLE, SEND, GUARD} state_t;

    state_t        state_q;
    logic [7:0]    rxMem_q [DEPTH];
    logic [7:0]    txMem_q [DEPTH];
    logic [PW-1:0] rxWptr_q, rxRptr_q, txWptr_q, txRptr_q;
    logic [PW-1:0] rxCount, txCount;
    logic          rxEmpty, rxFull, txEmpty, txFull;
    logic          rxOverrun_q, rxOverrun_d, txDrop_q, txDrop_d;
    logic          txStrobe_q;
    logic [7:0]    txData_q;
    logic          loopback;
    logic          rd, wr, dataRd, dataWr, statWr;
    logic          rxPop, rxPushReq, rxPush, txPush, startSend;
    logic [7:0]    txHead, rxHead, rxPushData;
    logic [15:0]   statusWord, dataWord;
    logic          unusedBits;

    assign unusedBits = ^{w[1], dwrite};

    assign rd     = sel & r & en;
    assign wr     = sel & w[0] & en;
    assign dataRd = rd & ~addr1;
    assign dataWr = wr & ~addr1;
    assign statWr = wr & addr1;

    assign rxCount = rxWptr_q - rxRptr_q;
    assign txCount = txWptr_q - txRptr_q;
    assign rxEmpty = (rxCount == '0);
    assign txEmpty = (txCount == '0);
    assign rxFull  = (rxCount == PW'(DEPTH));
    assign txFull  = (txCount == PW'(DEPTH));
    assign rxHead  = rxMem_q[rxRptr_q[AW-1:0]];
    assign txHead  = txMem_q[txRptr_q[AW-1:0]];

`ifdef B16_UART_LOOPBACK_EN
    logic loopback_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            loopback_q <= 1'b0;
        end else if (statWr) begin
            loopback_q <= dwrite[2];
        end
    end

    assign loopback = loopback_q;
`else
    assign loopback = 1'b0;
`endif

    // In loopback the transmitter feeds the RX FIFO and the uart is ignored entirely.
    assign startSend  = (state_q == IDLE) & ~txEmpty & (loopback | ~tx_busy);
    assign rxPop      = dataRd & ~rxEmpty;
    assign rxPushReq  = loopback ? startSend : rx_valid;
    assign rxPushData = loopback ? txHead : rx_data;
    assign rxPush     = rxPushReq & (~rxFull | rxPop);
    assign txPush     = dataWr & ~txFull;

    always_comb begin
        rxOverrun_d = (rxOverrun_q & ~(statWr & dwrite[15])) | (rxPushReq & rxFull & ~rxPop);
        txDrop_d    = (txDrop_q & ~(statWr & dwrite[14])) | (dataWr & txFull);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxWptr_q    <= '0;
            rxRptr_q    <= '0;
            txWptr_q    <= '0;
            txRptr_q    <= '0;
            rxOverrun_q <= 1'b0;
            txDrop_q    <= 1'b0;
        end else begin
            if (rxPush)    rxWptr_q <= rxWptr_q + PW'(1);
            if (rxPop)     rxRptr_q <= rxRptr_q + PW'(1);
            if (txPush)    txWptr_q <= txWptr_q + PW'(1);
            if (startSend) txRptr_q <= txRptr_q + PW'(1);
            rxOverrun_q <= rxOverrun_d;
            txDrop_q    <= txDrop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rxPush) rxMem_q[rxWptr_q[AW-1:0]] <= rxPushData;
        if (txPush) txMem_q[txWptr_q[AW-1:0]] <= dwrite[7:0];
    end

    // SEND and GUARD pad every transmission so the uart's busy flag has time to rise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            txStrobe_q <= 1'b0;
            txData_q   <= 8'h00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (startSend) begin
                        state_q <= SEND;
                        if (!loopback) begin
                            txStrobe_q <= 1'b1;
                            txData_q   <= txHead;
                        end
                    end
                end
                SEND: begin
                    txStrobe_q <= 1'b0;
                    state_q    <= GUARD;
                end
                GUARD:   state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_strobe = txStrobe_q;
    assign tx_data   = txData_q;

    always_comb begin
        statusWord       = 16'h0000;
        statusWord[0]    = ~rxEmpty;
        statusWord[1]    = ~txFull;
        statusWord[2]    = loopback;
        statusWord[7:4]  = 4'(rxCount);
        statusWord[11:8] = 4'(txCount);
        statusWord[14]   = txDrop_q;
        statusWord[15]   = rxOverrun_q;
        dataWord         = rxEmpty ? 16'h0000 : {8'h00, rxHead};
        rdata            = 16'h0000;
        if (sel) rdata = addr1 ? statusWord : dataWord;
    end

endmodule

// File: tb/tb_b16_uart_port.sv
// Self-checking bench for b16_uart_port: directed vector table, corner sequences and random traffic
// checked against a queue-based model of the port.
module tb_b16_uart_port;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel, en, addr1, r;
    logic [1:0]  w;
    logic [15:0] dwrite;
    logic [15:0] rdata;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_strobe;
    logic        tx_busy;

    int total = 0;
    int bad   = 0;

    logic [7:0] rxQ[$];
    logic [7:0] txQ[$];
    logic       mOvr, mDrop, mLoop, mStrobe;
    logic [7:0] mTxData;
    int         sinceSend;

    typedef struct {
        logic        sel, en, addr1, r, w0;
        logic [15:0] dwrite;
        logic        rxValid;
        logic [7:0]  rxData;
        logic [15:0] expRdata;
        logic        expStrobe;
        logic [7:0]  expTxData;
    } vec_t;

    vec_t tbl[12];

    b16_uart_port #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .sel(sel), .en(en), .addr1(addr1), .r(r), .w(w),
        .dwrite(dwrite), .rdata(rdata), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_strobe(tx_strobe), .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mkVec(logic s, logic e, logic a, logic rr, logic w0, logic [15:0] d,
                                   logic rv, logic [7:0] rd, logic [15:0] er, logic es, logic [7:0] et);
        vec_t v;
        v.sel = s; v.en = e; v.addr1 = a; v.r = rr; v.w0 = w0; v.dwrite = d;
        v.rxValid = rv; v.rxData = rd; v.expRdata = er; v.expStrobe = es; v.expTxData = et;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic e, input logic a, input logic rr,
                                 input logic w0, input logic [15:0] d, input logic rv,
                                 input logic [7:0] rd, input logic busy);
        sel = s; en = e; addr1 = a; r = rr; w = {1'b0, w0}; dwrite = d;
        rx_valid = rv; rx_data = rd; tx_busy = busy;
    endtask

    task automatic idle(input logic busy);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, busy);
    endtask

    task automatic modelReset();
        rxQ.delete(); txQ.delete();
        mOvr = 0; mDrop = 0; mLoop = 0; mStrobe = 0; mTxData = 8'h00; sinceSend = 3;
    endtask

    function automatic logic [15:0] expRdata();
        logic [15:0] s;
        if (!sel) return 16'h0000;
        if (!addr1) return (rxQ.size() == 0) ? 16'h0000 : {8'h00, rxQ[0]};
        s = 16'h0000;
        s[0]    = (rxQ.size() != 0);
        s[1]    = (txQ.size() != DEPTH);
        s[2]    = mLoop;
        s[7:4]  = 4'(rxQ.size());
        s[11:8] = 4'(txQ.size());
        s[14]   = mDrop;
        s[15]   = mOvr;
        return s;
    endfunction

    // Behaviour at one rising edge, from the inputs and model state just before it.
    task automatic modelEdge();
        logic rdq, wrq, rxPop, canSend, rxReq, rxFullPre, txFullPre, newOvr, newDrop, newLoop;
        logic [7:0] head, rxByte;
        rdq       = sel & r & en;
        wrq       = sel & w[0] & en;
        rxPop     = rdq && !addr1 && rxQ.size() > 0;
        canSend   = txQ.size() > 0 && (mLoop || !tx_busy) && sinceSend >= 3;
        head      = canSend ? txQ[0] : 8'h00;
        rxReq     = mLoop ? canSend : rx_valid;
        rxByte    = mLoop ? head : rx_data;
        rxFullPre = (rxQ.size() == DEPTH);
        txFullPre = (txQ.size() == DEPTH);
        newOvr    = (mOvr && !(wrq && addr1 && dwrite[15])) || (rxReq && rxFullPre && !rxPop);
        newDrop   = (mDrop && !(wrq && addr1 && dwrite[14])) || (wrq && !addr1 && txFullPre);
`ifdef B16_UART_LOOPBACK_EN
        newLoop   = (wrq && addr1) ? dwrite[2] : mLoop;
`else
        newLoop   = 1'b0;
`endif
        if (rxPop) void'(rxQ.pop_front());
        if (rxReq && (!rxFullPre || rxPop)) rxQ.push_back(rxByte);
        if (canSend) void'(txQ.pop_front());
        if (wrq && !addr1 && !txFullPre) txQ.push_back(dwrite[7:0]);
        mStrobe = canSend && !mLoop;
        if (mStrobe) mTxData = head;
        sinceSend = canSend ? 1 : ((sinceSend < 3) ? sinceSend + 1 : 3);
        mOvr = newOvr; mDrop = newDrop; mLoop = newLoop;
    endtask

    task automatic checkOutput();
        if (!sel || r) check("rdata", rdata, expRdata());
        check("tx_strobe", {15'h0, tx_strobe}, {15'h0, mStrobe});
        check("tx_data", {8'h00, tx_data}, {8'h00, mTxData});
    endtask

    task automatic finishCycle();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic runCycle();
        @(negedge clk);
        checkOutput();
        finishCycle();
    endtask

    task automatic doReset();
        idle(1'b0);
        reset = 1'b1;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        modelReset();
        @(posedge clk); #1;
    endtask

    initial begin
        int strobes, lastStrobe, minGap;
        logic [15:0] d;
        reset = 1'b0;
        modelReset();
        doReset();

        // Directed table: reset status, RX ordering, empty read, basic transmit.
        tbl[0]  = mkVec(1, 0, 1, 1, 0, 16'h0000, 0, 8'h00, 16'h0002, 0, 8'h00);
        tbl[1]  = mkVec(0, 0, 0, 0, 0, 16'h0000, 1, 8'h12, 16'h0000, 0, 8'h00);
        tbl[2]  = mkVec(1, 0, 1, 1, 0, 16'h0000, 1, 8'h34, 16'h0013, 0, 8'h00);
        tbl[3]  = mkVec(1, 0, 1, 1, 0, 16'h0000, 0, 8'h00, 16'h0023, 0, 8'h00);
        tbl[4]  = mkVec(1, 1, 0, 1, 0, 16'h0000, 0, 8'h00, 16'h0012, 0, 8'h00);
        tbl[5]  = mkVec(1, 1, 0, 1, 0, 16'h0000, 0, 8'h00, 16'h0034, 0, 8'h00);
        tbl[6]  = mkVec(1, 1, 0, 1, 0, 16'h0000, 0, 8'h00, 16'h0000, 0, 8'h00);
        tbl[7]  = mkVec(1, 0, 1, 1, 0, 16'h0000, 0, 8'h00, 16'h0002, 0, 8'h00);
        tbl[8]  = mkVec(1, 1, 0, 1, 1, 16'h0041, 0, 8'h00, 16'h0000, 0, 8'h00);
        tbl[9]  = mkVec(1, 0, 1, 1, 0, 16'h0000, 0, 8'h00, 16'h0102, 0, 8'h00);
        tbl[10] = mkVec(1, 0, 1, 1, 0, 16'h0000, 0, 8'h00, 16'h0002, 1, 8'h41);
        tbl[11] = mkVec(1, 0, 1, 1, 0, 16'h0000, 0, 8'h00, 16'h0002, 0, 8'h41);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(tbl[i].sel, tbl[i].en, tbl[i].addr1, tbl[i].r, tbl[i].w0,
                          tbl[i].dwrite, tbl[i].rxValid, tbl[i].rxData, 1'b0);
            @(negedge clk);
            check($sformatf("vec%0d_rdata", i), rdata, tbl[i].expRdata);
            check($sformatf("vec%0d_strobe", i), {15'h0, tx_strobe}, {15'h0, tbl[i].expStrobe});
            check($sformatf("vec%0d_txdata", i), {8'h00, tx_data}, {8'h00, tbl[i].expTxData});
            finishCycle();
        end

        // RX overrun: nine bytes into eight slots, clear, then full-plus-pop.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 16'h0, 1, 8'hA0 + 8'(i), 0);
            runCycle();
        end
        applyStimulus(1, 0, 1, 1, 0, 16'h0, 0, 8'h00, 0);
        @(negedge clk); checkOutput(); check("overrunStatus", rdata, 16'h8083); finishCycle();
        applyStimulus(1, 1, 1, 0, 1, 16'h8000, 0, 8'h00, 0);
        runCycle();
        applyStimulus(1, 0, 1, 1, 0, 16'h0, 0, 8'h00, 0);
        @(negedge clk); checkOutput(); check("overrunCleared", rdata, 16'h0083); finishCycle();
        applyStimulus(1, 1, 0, 1, 0, 16'h0, 1, 8'hEE, 0);
        @(negedge clk); checkOutput(); check("fullPopHead", rdata, 16'h00A0); finishCycle();
        applyStimulus(1, 0, 1, 1, 0, 16'h0, 0, 8'h00, 0);
        @(negedge clk); checkOutput(); check("fullPopNoOverrun", rdata, 16'h0083); finishCycle();
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1, 1, 0, 1, 0, 16'h0, 0, 8'h00, 0);
            runCycle();
        end

        // TX flow control: busy blocks sending, ninth byte dropped, then drain with spacing.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1, 1, 0, 0, 1, 16'h0060 + 16'(i), 0, 8'h00, 1);
            runCycle();
        end
        applyStimulus(1, 0, 1, 1, 0, 16'h0, 0, 8'h00, 1);
        @(negedge clk); checkOutput(); check("txFullStatus", rdata, 16'h4800); finishCycle();
        strobes = 0; lastStrobe = -100; minGap = 1000;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1, 0, 1, 1, 0, 16'h0, 0, 8'h00, 0);
            runCycle();
            if (tx_strobe) begin
                strobes++;
                if (i - lastStrobe < minGap) minGap = i - lastStrobe;
                lastStrobe = i;
            end
        end
        check("txStrobeCount", 16'(strobes), 16'd8);
        check("txMinGapOk", {15'h0, minGap >= 3}, 16'h0001);
        applyStimulus(1, 1, 1, 0, 1, 16'hC000, 0, 8'h00, 0);
        runCycle();

        // Stalled read: r held with en low must not pop.
        applyStimulus(0, 0, 0, 0, 0, 16'h0, 1, 8'h5A, 0);
        runCycle();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 0, 0, 1, 0, 16'h0, 0, 8'h00, 0);
            runCycle();
        end
        applyStimulus(1, 0, 0, 1, 0, 16'h0, 0, 8'h00, 0);
        @(negedge clk); checkOutput(); check("stallNoPop", rdata, 16'h005A); finishCycle();
        applyStimulus(1, 1, 0, 1, 0, 16'h0, 0, 8'h00, 0);
        runCycle();

        // Reset in the middle of a SEND cycle.
        applyStimulus(1, 1, 0, 0, 1, 16'h0077, 1, 8'h33, 0);
        runCycle();
        idle(1'b0);
        runCycle();
        check("strobeBeforeReset", {15'h0, tx_strobe}, 16'h0001);
        reset = 1'b1;
        applyStimulus(1, 0, 1, 1, 0, 16'h0, 0, 8'h00, 0);
        #1;
        check("resetStrobe", {15'h0, tx_strobe}, 16'h0000);
        check("resetTxData", {8'h00, tx_data}, 16'h0000);
        check("resetStatus", rdata, 16'h0002);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        modelReset();
        @(posedge clk); #1;

`ifdef B16_UART_LOOPBACK_EN
        applyStimulus(1, 1, 1, 0, 1, 16'h0004, 0, 8'h00, 0);
        runCycle();
        applyStimulus(1, 1, 0, 0, 1, 16'h0055, 0, 8'h00, 1);
        runCycle();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 16'h0, 1, 8'h99, 1);
            runCycle();
            check("loopNoStrobe", {15'h0, tx_strobe}, 16'h0000);
        end
        applyStimulus(1, 1, 0, 1, 0, 16'h0, 0, 8'h00, 0);
        @(negedge clk); checkOutput(); check("loopData", rdata, 16'h0055); finishCycle();
        applyStimulus(1, 1, 1, 0, 1, 16'h0000, 0, 8'h00, 0);
        runCycle();
`endif

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            d = 16'($urandom);
            if ($urandom_range(0, 3) != 0) d[15:14] = 2'b00;
            applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
                          $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                          $urandom_range(0, 2) == 0, d, $urandom_range(0, 9) < 3,
                          8'($urandom), $urandom_range(0, 9) < 3);
            runCycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
